// File: rtl/cover_toggle_collector.sv
// Toggle cover collector: sticky per-point hit bitmap, distinct-hit counter and a snapshot readout stream.
module cover_toggle_collector #(
  parameter int WIDTH       = 42,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8744,
  parameter int WORD_W      = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         en,
  input  logic                         clear,
  input  logic                         dump_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic [31:0]                  out_index,
  output logic                         out_last,
  output logic [31:0]                  out_total,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         new_hit
);

  localparam int NWORDS = (WIDTH + WORD_W - 1) / WORD_W;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t                    state_q;
  logic [WIDTH-1:0]          bitmap_q, bitmap_d;
  logic [WIDTH-1:0]          snapshot_q;
  logic [CW-1:0]             hit_count_q, hit_count_d;
  logic                      new_hit_q, new_hit_d;
  logic [WCW-1:0]            word_q;
  logic                      out_valid_q;
  logic [WORD_W-1:0]         out_data_q;
  logic [31:0]               out_index_q;
  logic                      out_last_q;
  logic                      busy_q;

  logic [WIDTH-1:0]          fresh;
  logic [CW-1:0]             fresh_cnt;
  logic [NWORDS*WORD_W-1:0]  snap_pad;
  logic [WORD_W-1:0]         word_data;
  logic [31:0]               word_index;
  logic                      word_is_last;

  assign fresh = valid & ~bitmap_q & {WIDTH{en}};

  always_comb begin
    fresh_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fresh_cnt = fresh_cnt + CW'(fresh[i]);
    end
  end

  // Count can only grow by points not yet in the bitmap, so it tops out at WIDTH.
  always_comb begin
    bitmap_d    = bitmap_q | fresh;
    hit_count_d = hit_count_q + fresh_cnt;
    new_hit_d   = |fresh;
    if (clear) begin
      bitmap_d    = '0;
      hit_count_d = '0;
      new_hit_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitmap_q    <= '0;
      hit_count_q <= '0;
      new_hit_q   <= 1'b0;
    end else begin
      bitmap_q    <= bitmap_d;
      hit_count_q <= hit_count_d;
      new_hit_q   <= new_hit_d;
    end
  end

  always_comb begin
    snap_pad              = '0;
    snap_pad[WIDTH-1:0]   = snapshot_q;
  end

  assign word_data    = snap_pad[int'(word_q)*WORD_W +: WORD_W];
  assign word_index   = 32'(COVER_INDEX) + 32'(word_q) * 32'(WORD_W);
  assign word_is_last = (word_q == WCW'(NWORDS - 1));

  // Snapshot takes the pre-update bitmap, so a same-cycle clear cannot empty it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      snapshot_q  <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= 32'(COVER_INDEX);
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dump_req) begin
            snapshot_q <= bitmap_q;
            word_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          out_data_q  <= word_data;
          out_index_q <= word_index;
          out_last_q  <= word_is_last;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              word_q  <= word_q + WCW'(1);
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign out_total = 32'(COVER_TOTAL);
  assign busy      = busy_q;
  assign hit_count = hit_count_q;
  assign new_hit   = new_hit_q;

endmodule
